// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared defaults and next-PC select encoding for pc_unit
package pc_pkg;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_4180;
  localparam logic [31:0] DEF_IM_BASE   = 32'h0000_3000;

  typedef enum logic [2:0] {
    SEL_EXC,
    SEL_ERET,
    SEL_HOLD,
    SEL_REDIR,
    SEL_PEND,
    SEL_SEQ
  } pc_sel_e;

  // First match wins; exception entry and eret bypass the stall.
  function automatic pc_sel_e pc_select(input logic exc_req, input logic eret,
                                        input logic stall, input logic redirect,
                                        input logic pend_valid);
    if (exc_req)         return SEL_EXC;
    else if (eret)       return SEL_ERET;
    else if (stall)      return SEL_HOLD;
    else if (redirect)   return SEL_REDIR;
    else if (pend_valid) return SEL_PEND;
    else                 return SEL_SEQ;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - circular return-address stack, oldest entry overwritten when full
module pc_ras #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_pc,
  input  logic              pop,
  output logic [ADDR_W-1:0] top,
  output logic              valid
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PTR_W-1:0]  ptr_inc;

  // Stack update: flush, replace-top, push (wraps onto oldest), or pop.
  always_comb begin
    mem_d   = mem_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    ptr_inc = ptr_q + PTR_W'(1);
    if (flush) begin
      ptr_d = '0;
      cnt_d = '0;
    end else if (push && pop) begin
      if (cnt_q != '0) mem_d[ptr_q] = push_pc;
    end else if (push) begin
      ptr_d          = ptr_inc;
      mem_d[ptr_inc] = push_pc;
      if (cnt_q != CNT_W'(DEPTH)) cnt_d = cnt_q + CNT_W'(1);
    end else if (pop && cnt_q != '0) begin
      ptr_d = ptr_q - PTR_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage; contents are only visible while the count is non-zero.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign valid = (cnt_q != '0);
  assign top   = valid ? mem_q[ptr_q] : '0;

endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - fetch-stage PC with pending redirect, fetch fault and optional RAS (PC_RAS_EN)
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(DEF_RESET_VEC),
  parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(DEF_EXC_VEC),
  parameter logic [ADDR_W-1:0] IM_BASE   = ADDR_W'(DEF_IM_BASE),
  parameter int unsigned       IM_WORDS  = 4096,
  parameter int unsigned       RAS_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        stall,
  input  logic                        redirect,
  input  logic [ADDR_W-1:0]           redirect_pc,
  input  logic                        exc_req,
  input  logic                        eret,
  input  logic [ADDR_W-1:0]           epc,
  output logic [ADDR_W-1:0]           pc,
  output logic [ADDR_W-1:0]           pc_plus4,
  output logic [$clog2(IM_WORDS)-1:0] im_index,
  output logic                        fetch_exc,
  input  logic                        ras_push,
  input  logic [ADDR_W-1:0]           ras_push_pc,
  input  logic                        ras_pop,
  output logic [ADDR_W-1:0]           ras_top,
  output logic                        ras_valid
);

  localparam int unsigned IDX_W = $clog2(IM_WORDS);
  // One bit wider so a window ending at 2^ADDR_W does not wrap to zero.
  localparam logic [ADDR_W:0] IM_LIMIT = {1'b0, IM_BASE} + (ADDR_W+1)'(4 * IM_WORDS);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              pend_valid_q, pend_valid_d;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
  pc_sel_e           sel;

  // Next-PC selection and pending-redirect bookkeeping.
  always_comb begin
    sel          = pc_select(exc_req, eret, stall, redirect, pend_valid_q);
    pc_d         = pc_q;
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;
    case (sel)
      SEL_EXC:   pc_d = EXC_VEC;
      SEL_ERET:  pc_d = epc;
      SEL_HOLD:  pc_d = pc_q;
      SEL_REDIR: pc_d = redirect_pc;
      SEL_PEND:  pc_d = pend_pc_q;
      default:   pc_d = pc_q + ADDR_W'(4);
    endcase
    if (exc_req || eret || !stall) begin
      pend_valid_d = 1'b0;
    end else if (redirect) begin
      pend_valid_d = 1'b1;
      pend_pc_d    = redirect_pc;
    end
  end

  // PC and pending-latch registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= RESET_VEC;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= '0;
    end else begin
      pc_q         <= pc_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
    end
  end

  assign pc        = pc_q;
  assign pc_plus4  = pc_q + ADDR_W'(4);
  assign im_index  = IDX_W'((pc_q - IM_BASE) >> 2);
  assign fetch_exc = (pc_q[1:0] != 2'b00) || (pc_q < IM_BASE) || ({1'b0, pc_q} >= IM_LIMIT);

`ifdef PC_RAS_EN
  pc_ras #(
    .ADDR_W (ADDR_W),
    .DEPTH  (RAS_DEPTH)
  ) u_ras (
    .clk     (clk),
    .reset   (reset),
    .flush   (exc_req | eret),
    .push    (ras_push & ~stall),
    .push_pc (ras_push_pc),
    .pop     (ras_pop & ~stall),
    .top     (ras_top),
    .valid   (ras_valid)
  );
`else
  localparam int unsigned RAS_DEPTH_UNUSED = RAS_DEPTH;
  logic ras_inputs_unused;
  assign ras_inputs_unused = ^{ras_push, ras_push_pc, ras_pop, RAS_DEPTH_UNUSED[0]};
  assign ras_top   = '0;
  assign ras_valid = 1'b0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - directed table, RAS sequences and randomized model check for pc_unit
module tb_pc_unit;

  localparam logic [31:0] BASE  = 32'h0000_3000;
  localparam logic [31:0] LIMIT = 32'h0000_7000;
  localparam logic [31:0] EXCV  = 32'h0000_4180;
  localparam int          DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset, stall, redirect, exc_req, eret, ras_push, ras_pop;
  logic [31:0] redirect_pc, epc, ras_push_pc;
  logic [31:0] pc, pc_plus4, ras_top;
  logic [11:0] im_index;
  logic        fetch_exc, ras_valid;

  always #5 clk = ~clk;

  pc_unit #(
    .ADDR_W(32), .RESET_VEC(32'h0000_3000), .EXC_VEC(32'h0000_4180),
    .IM_BASE(32'h0000_3000), .IM_WORDS(4096), .RAS_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .exc_req(exc_req), .eret(eret), .epc(epc),
    .pc(pc), .pc_plus4(pc_plus4), .im_index(im_index), .fetch_exc(fetch_exc),
    .ras_push(ras_push), .ras_push_pc(ras_push_pc), .ras_pop(ras_pop),
    .ras_top(ras_top), .ras_valid(ras_valid)
  );

  int n_checks = 0;
  int n_fail   = 0;

`ifdef PC_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif

  // Reference model state.
  logic [31:0] m_pc;
  bit          m_pend_v;
  logic [31:0] m_pend;
  logic [31:0] m_ras [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    if (reset) begin
      m_pc = 32'h0000_3000; m_pend_v = 0; m_pend = 0; m_ras.delete();
    end else if (exc_req || eret) begin
      m_pc = exc_req ? EXCV : epc;
      m_pend_v = 0;
      m_ras.delete();
    end else if (stall) begin
      if (redirect) begin m_pend_v = 1; m_pend = redirect_pc; end
    end else begin
      if (redirect)      m_pc = redirect_pc;
      else if (m_pend_v) m_pc = m_pend;
      else               m_pc = m_pc + 32'd4;
      m_pend_v = 0;
      if (RAS_EN) begin
        if (ras_push && ras_pop) begin
          if (m_ras.size() > 0) m_ras[m_ras.size()-1] = ras_push_pc;
        end else if (ras_push) begin
          m_ras.push_back(ras_push_pc);
          if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
        end else if (ras_pop && m_ras.size() > 0) begin
          void'(m_ras.pop_back());
        end
      end
    end
  endtask

  task automatic check_all();
    logic [31:0] off, e_idx, e_top;
    bit          e_fe;
    off   = m_pc - BASE;
    e_idx = {20'd0, off[13:2]};
    e_fe  = (m_pc[1:0] != 2'b00) || (m_pc < BASE) || (m_pc >= LIMIT);
    e_top = (m_ras.size() > 0) ? m_ras[m_ras.size()-1] : 32'd0;
    chk("pc", pc, m_pc);
    chk("pc_plus4", pc_plus4, m_pc + 32'd4);
    chk("im_index", {20'd0, im_index}, e_idx);
    chk("fetch_exc", {31'd0, fetch_exc}, {31'd0, e_fe});
    chk("ras_top", ras_top, e_top);
    chk("ras_valid", {31'd0, ras_valid}, {31'd0, m_ras.size() > 0});
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    reset = 0; stall = 0; redirect = 0; redirect_pc = 0; exc_req = 0; eret = 0;
    epc = 0; ras_push = 0; ras_push_pc = 0; ras_pop = 0;
  endtask

  typedef struct {
    bit          rst, stl, rdr;
    logic [31:0] rpc;
    bit          exc, ert;
    logic [31:0] epc;
    logic [31:0] exp_pc;
    bit          exp_fe;
  } vec_t;

  vec_t vecs [$];

  function automatic vec_t mk(bit rst, bit stl, bit rdr, logic [31:0] rpc, bit exc, bit ert,
                              logic [31:0] e, logic [31:0] exp_pc, bit exp_fe);
    vec_t v;
    v.rst = rst; v.stl = stl; v.rdr = rdr; v.rpc = rpc; v.exc = exc; v.ert = ert;
    v.epc = e; v.exp_pc = exp_pc; v.exp_fe = exp_fe;
    return v;
  endfunction

  initial begin
    // Reset and free-running fetch.
    vecs.push_back(mk(1,0,0,0,0,0,0, 32'h3000, 0));
    vecs.push_back(mk(0,0,0,0,0,0,0, 32'h3004, 0));
    vecs.push_back(mk(0,0,0,0,0,0,0, 32'h3008, 0));
    vecs.push_back(mk(0,0,0,0,0,0,0, 32'h300C, 0));
    vecs.push_back(mk(0,0,0,0,0,0,0, 32'h3010, 0));
    // Redirect captured during a stall is applied afterwards.
    vecs.push_back(mk(0,1,1,32'h3100,0,0,0, 32'h3010, 0));
    vecs.push_back(mk(0,1,0,0,0,0,0, 32'h3010, 0));
    vecs.push_back(mk(0,0,0,0,0,0,0, 32'h3100, 0));
    vecs.push_back(mk(0,0,0,0,0,0,0, 32'h3104, 0));
    // Exception beats stall/redirect and drops the pending target; eret returns.
    vecs.push_back(mk(0,1,1,32'h3200,1,0,0, 32'h4180, 0));
    vecs.push_back(mk(0,0,0,0,0,0,0, 32'h4184, 0));
    vecs.push_back(mk(0,1,0,0,0,1,32'h3020, 32'h3020, 0));
    vecs.push_back(mk(0,0,0,0,0,0,0, 32'h3024, 0));
    // Fetch-fault boundaries.
    vecs.push_back(mk(0,0,1,32'h3002,0,0,0, 32'h3002, 1));
    vecs.push_back(mk(0,0,1,32'h2FFC,0,0,0, 32'h2FFC, 1));
    vecs.push_back(mk(0,0,1,32'h6FFC,0,0,0, 32'h6FFC, 0));
    vecs.push_back(mk(0,0,0,0,0,0,0, 32'h7000, 1));
    // Reset mid-stall drops a pending redirect.
    vecs.push_back(mk(0,0,1,32'h3040,0,0,0, 32'h3040, 0));
    vecs.push_back(mk(0,1,1,32'h3300,0,0,0, 32'h3040, 0));
    vecs.push_back(mk(1,1,0,0,0,0,0, 32'h3000, 0));
    vecs.push_back(mk(0,0,0,0,0,0,0, 32'h3004, 0));
    vecs.push_back(mk(0,0,0,0,0,0,0, 32'h3008, 0));
    // Later capture overwrites; a fresh redirect beats the pending target.
    vecs.push_back(mk(0,1,1,32'h3400,0,0,0, 32'h3008, 0));
    vecs.push_back(mk(0,1,1,32'h3480,0,0,0, 32'h3008, 0));
    vecs.push_back(mk(0,0,1,32'h3500,0,0,0, 32'h3500, 0));
    vecs.push_back(mk(0,0,0,0,0,0,0, 32'h3504, 0));
    vecs.push_back(mk(0,1,1,32'h3600,0,0,0, 32'h3504, 0));
    vecs.push_back(mk(0,0,0,0,0,0,0, 32'h3600, 0));

    idle();
    foreach (vecs[i]) begin
      reset = vecs[i].rst; stall = vecs[i].stl; redirect = vecs[i].rdr;
      redirect_pc = vecs[i].rpc; exc_req = vecs[i].exc; eret = vecs[i].ert; epc = vecs[i].epc;
      cycle();
      chk($sformatf("tbl_pc[%0d]", i), pc, vecs[i].exp_pc);
      chk($sformatf("tbl_fexc[%0d]", i), {31'd0, fetch_exc}, {31'd0, vecs[i].exp_fe});
    end

    // RAS: nine pushes into an eight-deep stack, then drain.
    idle(); reset = 1; cycle(); idle();
    chk("ras_reset_valid", {31'd0, ras_valid}, 32'd0);
    chk("ras_reset_top", ras_top, 32'd0);
    for (int i = 1; i <= 9; i++) begin
      ras_push = 1; ras_push_pc = 32'h1000 + 32'(i) * 4;
      cycle();
    end
    idle();
    for (int k = 0; k < 8; k++) begin
`ifdef PC_RAS_EN
      chk($sformatf("ras_lifo[%0d]", k), ras_top, 32'h1000 + 32'(9 - k) * 4);
`endif
      ras_pop = 1; cycle();
    end
    idle();
    chk("ras_drained_valid", {31'd0, ras_valid}, 32'd0);
    ras_pop = 1; cycle(); idle();
    chk("ras_pop_empty", {31'd0, ras_valid}, 32'd0);
    ras_push = 1; ras_push_pc = 32'h2000; cycle();
    ras_push_pc = 32'h2004; cycle();
    ras_pop = 1; ras_push_pc = 32'h2008; cycle(); idle();
`ifdef PC_RAS_EN
    chk("ras_replace_top", ras_top, 32'h2008);
`endif
    ras_pop = 1; cycle(); idle();
`ifdef PC_RAS_EN
    chk("ras_after_replace", ras_top, 32'h2000);
`endif
    stall = 1; ras_pop = 1; cycle(); idle();
`ifdef PC_RAS_EN
    chk("ras_stall_blocks", ras_top, 32'h2000);
`endif
    exc_req = 1; cycle(); idle();
    chk("ras_flush_exc", {31'd0, ras_valid}, 32'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      reset       = ($urandom_range(0, 63) == 0);
      exc_req     = ($urandom_range(0, 15) == 0);
      eret        = ($urandom_range(0, 15) == 0);
      stall       = ($urandom_range(0, 3) == 0);
      redirect    = ($urandom_range(0, 2) == 0);
      redirect_pc = ($urandom_range(0, 7) == 0) ? $urandom : BASE + ($urandom_range(0, 4095) << 2);
      epc         = BASE + ($urandom_range(0, 4095) << 2);
      ras_push    = ($urandom_range(0, 3) == 0);
      ras_pop     = ($urandom_range(0, 3) == 0);
      ras_push_pc = $urandom;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
